sdram_arbiter: RTL

Two-port Avalon-MM arbiter sharing the single SDRAM controller slave in the DNN accelerator system between the accelerator's read engine (port m0: weights/activations) and its write-back engine (port m1: output activations). It grants one whole transaction at a time using round-robin priority. It allows up to MAX_PEND pipelined reads in flight and routes each returning read word to the requester that issued it, using an in-order tag FIFO.

---
 rtl/dnn_accel_pkg.sv | 12 +
 rtl/sdram_arbiter_if.sv | 31 +++
 rtl/sdram_tag_fifo.sv | 51 +++++
 rtl/sdram_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/dnn_accel_pkg.sv
// Shared types for the DNN accelerator memory subsystem.
// Arbiter state encoding and requester port id.
package dnn_accel_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  typedef logic port_id_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// One Avalon-MM link: command toward the slave,
// stall and read return back toward the master.
interface sdram_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write,
    output writedata, byteenable,
    input  waitrequest, readdata,
    input  readdatavalid
  );

  modport slave (
    input  address, read, write,
    input  writedata, byteenable,
    output waitrequest, readdata,
    output readdatavalid
  );

endinterface

// File: rtl/sdram_tag_fifo.sv
// In-order FIFO of 1-bit port tags for reads in flight.
// Holds which requester owns each pending read return.
module sdram_tag_fifo
  import dnn_accel_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  port_id_t    din,
  input  logic        pop,
  output port_id_t    head,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);

  port_id_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + (AW+1)'(1);
      else if (do_pop && !do_push)
        count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin two-port Avalon-MM arbiter in front of the
// SDRAM controller, with in-order read return routing.
module sdram_arbiter
  import dnn_accel_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_PEND = 4
) (
  input  logic            clk,
  input  logic            rst,
  sdram_arbiter_if.slave  m0,
  sdram_arbiter_if.slave  m1,
  sdram_arbiter_if.master sd,
  output logic            err
);

  localparam int CW = $clog2(MAX_PEND) + 1;

  arb_state_t state, state_d;
  port_id_t   gnt, gnt_d;
  port_id_t   last, last_d;
  port_id_t   head;

  logic [ADDR_W-1:0]   g_addr;
  logic [DATA_W-1:0]   g_wdata;
  logic [DATA_W/8-1:0] g_be;
  logic [CW-1:0]       count;

  logic req0, req1, g_rd, g_wr;
  logic blocked, push, pop;
  logic full, empty;
  logic rd_o, wr_o, wait0, wait1;

  assign req0    = m0.read | m0.write;
  assign req1    = m1.read | m1.write;
  assign g_rd    = gnt ? m1.read       : m0.read;
  assign g_wr    = gnt ? m1.write      : m0.write;
  assign g_addr  = gnt ? m1.address    : m0.address;
  assign g_wdata = gnt ? m1.writedata  : m0.writedata;
  assign g_be    = gnt ? m1.byteenable : m0.byteenable;

  // Full is judged on the registered count, not on a same-cycle pop.
  assign blocked = g_rd && full;

  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    last_d  = last;
    rd_o    = 1'b0;
    wr_o    = 1'b0;
    wait0   = 1'b1;
    wait1   = 1'b1;
    push    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_d = GRANT;
          if (req0 && req1) gnt_d = ~last;
          else              gnt_d = req1;
        end
      end
      GRANT: begin
        rd_o = g_rd && !blocked;
        wr_o = g_wr;
        if (gnt) wait1 = blocked | sd.waitrequest;
        else     wait0 = blocked | sd.waitrequest;
        if ((rd_o || wr_o) && !sd.waitrequest) begin
          state_d = IDLE;
          last_d  = gnt;
          push    = rd_o;
        end else if (!g_rd && !g_wr) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      gnt   <= gnt_d;
      last  <= last_d;
      if (sd.readdatavalid && empty) err <= 1'b1;
    end
  end

  assign pop = sd.readdatavalid && !empty;

  sdram_tag_fifo #(.DEPTH(MAX_PEND)) u_tags (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (gnt),
    .pop   (pop),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign sd.address       = g_addr;
  assign sd.writedata     = g_wdata;
  assign sd.byteenable    = g_be;
  assign sd.read          = rd_o;
  assign sd.write         = wr_o;
  assign m0.waitrequest   = wait0;
  assign m1.waitrequest   = wait1;
  assign m0.readdata      = sd.readdata;
  assign m1.readdata      = sd.readdata;
  assign m0.readdatavalid = pop && !head;
  assign m1.readdatavalid = pop && head;

endmodule
